// File: rtl/steg_sinp_loader.sv
// Multi-channel serial-to-parallel loader: NCH bit-serial streams into WIDTH-bit words, valid/ready output.
// Define SINP_LSB_FIRST_EN for LSB-first assembly; default is MSB-first.

module steg_sinp_lane #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             restart,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shifted;

`ifdef SINP_LSB_FIRST_EN
    assign seed    = {bit_in, {(WIDTH-1){1'b0}}};
    assign shifted = {bit_in, word[WIDTH-1:1]};
`else
    assign seed    = {{(WIDTH-1){1'b0}}, bit_in};
    assign shifted = {word[WIDTH-2:0], bit_in};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            word <= '0;
        else if (restart)
            word <= seed;
        else if (shift_en)
            word <= shifted;
    end

endmodule

module steg_sinp_loader #(
    parameter  int WIDTH = 128,
    parameter  int NCH   = 3,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               sin_valid,
    input  logic [NCH-1:0]     sin,
    output logic [NCH*WIDTH-1:0] pout,
    output logic               pout_valid,
    input  logic               pout_ready,
    output logic [CW-1:0]      count,
    output logic               flag_sinp,
    output logic               ovf
);

    typedef enum logic {LOAD, FULL} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                      state_q, state_d;
    logic   [CW-1:0]             count_d;
    logic                        ovf_d;
    logic                        flag_d;
    logic                        shift_en;
    logic                        restart;
    logic   [NCH-1:0][WIDTH-1:0] words;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            count     <= '0;
            ovf       <= 1'b0;
            flag_sinp <= 1'b0;
        end else begin
            state_q   <= state_d;
            count     <= count_d;
            ovf       <= ovf_d;
            flag_sinp <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count;
        ovf_d    = ovf;
        flag_d   = 1'b0;
        shift_en = 1'b0;
        restart  = 1'b0;
        if (clear) begin
            state_d = LOAD;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (sin_valid) begin
                        shift_en = 1'b1;
                        if (count == LAST) begin
                            state_d = FULL;
                            count_d = '0;
                            flag_d  = 1'b1;
                        end else begin
                            count_d = count + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (pout_ready) begin
                        state_d = LOAD;
                        // A bit arriving with the handshake opens the next word immediately.
                        if (sin_valid) begin
                            restart = 1'b1;
                            count_d = CW'(1);
                        end
                    end else if (sin_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        steg_sinp_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .shift_en (shift_en),
            .restart  (restart),
            .bit_in   (sin[k]),
            .word     (words[k])
        );
    end

    assign pout       = words;
    assign pout_valid = (state_q == FULL);

endmodule

// File: doc/steg_sinp_loader.md
# steg_sinp_loader

Parametrised multi-channel serial-to-parallel loader for the AES steganography datapath. It captures NCH bit-serial streams (key, payload, IV in the default build) into WIDTH-bit words in lock-step. It presents the assembled words on a valid/ready handshake to the AES core, with a bit counter, a completion pulse and overflow detection. It replaces the fixed 128-bit, free-running serial input stage with a flow-controlled, width- and channel-generic block.

## Interface
- WIDTH, 128, bits per word per channel (≥2)
- NCH, 3, number of serial channels (ch0 = key, ch1 = payload, ch2 = IV in the default build)
- CW, $clog2(WIDTH), counter width (derived, not overridden)

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous abort: discard partial or held word
- sin_valid  in  1  qualifies sin this cycle
- sin  in  NCH  one serial bit per channel, sampled together
- pout  out  NCH*WIDTH  assembled words; channel k on pout[k*WIDTH +: WIDTH]
- pout_valid  out  1  words complete and held
- pout_ready  in  1  consumer accepts pout
- count  out  CW  bits captured into the current word (0..WIDTH-1)
- flag_sinp  out  1  one-cycle pulse on the cycle pout_valid rises
- ovf  out  1  sticky: a bit was offered while a word was held and not accepted

## Operation
- Two states: LOAD and FULL. Reset state is LOAD.
- LOAD, sin_valid=1: each channel's shift register takes sin[k] and count increments.
  - When count==WIDTH-1, the bit completes the word: next state FULL, count returns to 0, and flag_sinp pulses next cycle.
- LOAD, sin_valid=0: no change.
- FULL: shift registers frozen; pout_valid=1 and pout stable.
  - pout_valid && pout_ready: handshake completes; next state LOAD.
  - Handshake with sin_valid=1 in the same cycle: the bit is accepted as bit 0 of the next word (shift registers cleared, then loaded with that bit) and count=1. No dead cycle.
  - sin_valid=1 without pout_ready: the bit is dropped, ovf set, and state, count and pout are unchanged.
- ovf clears only on rst_n=0 or clear=1.
- clear=1 (rst_n=1): state LOAD, count 0, shift registers 0, ovf 0, pout_valid 0, no flag_sinp. clear overrides sin_valid and pout_ready in the same cycle.
- Priority: rst_n, then clear, then handshake, then shift.
- pout reflects the shift registers at all times; it is meaningful only while pout_valid=1.
- Counter arithmetic is unsigned CW bits. Completion compares against WIDTH-1, so a non-power-of-2 WIDTH never wraps through unused codes.

## Timing
- Reset values: pout=0, pout_valid=0, count=0, flag_sinp=0, ovf=0.
- All outputs are registered, with no combinational input-to-output path.
- Latency: the last bit sampled at edge N gives pout_valid=1 and flag_sinp=1 after edge N. flag_sinp returns to 0 after edge N+1.
- Minimum word period is WIDTH cycles, achieved when pout_ready is held high with continuous sin_valid.
- pout_ready is ignored in LOAD.
- Reset or clear mid-word discards the partial word. The next word starts at count 0.

## Configuration
- SINP_LSB_FIRST_EN undefined (default): MSB-first. The first bit received lands in pout bit WIDTH-1 of each channel (shift left, insert at bit 0).
- SINP_LSB_FIRST_EN defined: LSB-first. The first bit received lands in bit 0 (shift right, insert at bit WIDTH-1).
- Counter, handshake and flags are identical in both builds.

## Test plan
- Default build, continuous sin_valid for 128 cycles, MSB-first:
  - Inputs: ch0=128'h416264756C4D6F697A536865696B686B, ch1=128'h596F75617265746865626573746D616E, ch2=128'h74686973697363686169746869736973.
  - Required: pout_valid=1, flag_sinp single pulse, pout equals {ch2,ch1,ch0}, count=0.
- Hold pout_ready=0 for 5 cycles with sin_valid=1 while FULL:
  - pout unchanged, ovf=1.
  - Then pout_ready=1 with sin_valid=1: handshake, count=1, ovf stays 1 until clear.
- Back-to-back: pout_ready tied 1, 256 continuous bits. Two flag_sinp pulses exactly 128 cycles apart; second word correct.
- clear after 60 bits: count=0, pout=0. A following full 128-bit load produces the correct word.
- rst_n=0 for one cycle mid-word (count=37): all outputs at reset values on the next cycle.
- SINP_LSB_FIRST_EN build, WIDTH=8, NCH=1, bits 1,0,0,0,0,0,0,0 in order: pout=8'h01. The default build gives pout=8'h80.
